// File: rtl/mem_responder.sv
// Word-wide synchronous RAM responder with configurable wait states and a one-cycle ready pulse.
// Optional MEM_PARITY_EN macro adds a stored even-parity bit per word and a parity_inject input.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_PARITY_EN
  input  logic              parity_inject,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              req_err
);

`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam bit         HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] WS_CNT   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_req_prev;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_is_write;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_mem_ready;
  logic                r_busy;
  logic                r_req_err;
  logic [MEM_W-1:0]    r_mem [0:DEPTH-1];

  logic                w_req;
  logic                w_accept;
  logic                w_mem_we;
  logic [MEM_W-1:0]    w_wr_word;
  logic [MEM_W-1:0]    w_rd_word;
  logic                w_par_err;

  assign w_req     = mem_read | mem_write;
  assign w_accept  = (r_state == S_IDLE) && w_req && !r_req_prev;
  assign w_mem_we  = (r_state == S_ACCESS) && r_is_write;
  assign w_rd_word = r_mem[r_addr];

`ifdef MEM_PARITY_EN
  logic r_inject;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_inject <= 1'b0;
    else if (w_accept) r_inject <= parity_inject;
  end

  assign w_wr_word = {(^r_wdata) ^ r_inject, r_wdata};
  assign w_par_err = ^w_rd_word;
`else
  assign w_wr_word = r_wdata;
  assign w_par_err = 1'b0;
`endif

  // Array has no reset so it maps onto a plain RAM; async reset of r_state blocks a pending write.
  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[r_addr] <= w_wr_word;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_req_prev  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_is_write  <= 1'b0;
      r_rdata     <= '0;
      r_mem_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_req_err   <= 1'b0;
    end else begin
      r_req_prev  <= w_req;
      r_mem_ready <= 1'b0;
      r_req_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr     <= addr;
            r_wdata    <= wdata;
            r_is_write <= mem_write;
            r_busy     <= 1'b1;
            if (mem_read && mem_write) begin
              r_state     <= S_DONE;
              r_mem_ready <= 1'b1;
              r_req_err   <= 1'b1;
            end else if (HAS_WAIT) begin
              r_state <= S_WAIT;
              r_cnt   <= 4'd1;
            end else begin
              r_state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == WS_CNT) begin
            r_state <= S_ACCESS;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_ACCESS: begin
          if (!r_is_write) r_rdata <= w_rd_word[DATA_W-1:0];
          r_req_err   <= !r_is_write && w_par_err;
          r_mem_ready <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rdata     = r_rdata;
  assign mem_ready = r_mem_ready;
  assign busy      = r_busy;
  assign req_err   = r_req_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed table-driven bench for mem_responder; runs a 2-wait-state and a 0-wait-state instance
// side by side on shared request inputs, plus hand sequences for held levels and mid-wait reset.
module tb_mem_responder;

  logic        clock;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [8:0]  addr;
  logic [31:0] wdata;
`ifdef MEM_PARITY_EN
  logic        parity_inject;
`endif
  logic [31:0] rdata2, rdata0;
  logic        ready2, ready0, busy2, busy0, err2, err0;

  int n_vec  = 0;
  int n_miss = 0;

  int first2, first0, rcnt2, rcnt0, bcnt2, bcnt0, ecnt2, ecnt0;

  mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(2)) u_ws2 (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata),
`ifdef MEM_PARITY_EN
    .parity_inject(parity_inject),
`endif
    .rdata(rdata2), .mem_ready(ready2), .busy(busy2), .req_err(err2)
  );

  mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(0)) u_ws0 (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata),
`ifdef MEM_PARITY_EN
    .parity_inject(parity_inject),
`endif
    .rdata(rdata0), .mem_ready(ready0), .busy(busy0), .req_err(err0)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [8:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Raises the request at a negedge, samples n negedges, scrambles addr/wdata after the first
  // sample to show they were latched, then drops the request.
  task automatic run_txn(input logic rd, input logic wr, input logic [8:0] a,
                         input logic [31:0] d, input int n);
    @(negedge clock);
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    first2 = 0; first0 = 0; rcnt2 = 0; rcnt0 = 0;
    bcnt2 = 0; bcnt0 = 0; ecnt2 = 0; ecnt0 = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      if (ready2) begin rcnt2++; if (first2 == 0) first2 = k; end
      if (ready0) begin rcnt0++; if (first0 == 0) first0 = k; end
      if (busy2) bcnt2++;
      if (busy0) bcnt0++;
      if (err2) ecnt2++;
      if (err0) ecnt0++;
      if (k == 1) begin addr = ~a; wdata = ~d; end
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    int lat2, lat0;

    vecs[0]  = '{1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 9'h005, 32'h00000000, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 9'h1FF, 32'h00000001, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 9'h1FF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 9'h010, 32'h12345678, 32'h00000001, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 9'h010, 32'hFFFFFFFF, 32'h00000001, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 9'h010, 32'h00000000, 32'h12345678, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 9'h000, 32'hA5A5A5A5, 32'h12345678, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 9'h000, 32'h00000000, 32'hA5A5A5A5, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 9'h020, 32'h00000000, 32'hA5A5A5A5, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 9'h005, 32'h00000000, 32'hDEADBEEF, 1'b0};

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
`ifdef MEM_PARITY_EN
    parity_inject = 1'b0;
`endif
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_rdata_ws2", rdata2, 32'h0);
    check("reset_rdata_ws0", rdata0, 32'h0);
    check("reset_ctl_ws2", {29'h0, ready2, busy2, err2}, 32'h0);
    check("reset_ctl_ws0", {29'h0, ready0, busy0, err0}, 32'h0);

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, 7);
      lat2 = vecs[i].exp_err ? 1 : 4;
      lat0 = vecs[i].exp_err ? 1 : 2;
      check($sformatf("v%0d_lat_ws2", i), 32'(first2), 32'(lat2));
      check($sformatf("v%0d_lat_ws0", i), 32'(first0), 32'(lat0));
      check($sformatf("v%0d_npulse_ws2", i), 32'(rcnt2), 32'd1);
      check($sformatf("v%0d_npulse_ws0", i), 32'(rcnt0), 32'd1);
      check($sformatf("v%0d_busy_ws2", i), 32'(bcnt2), 32'(lat2));
      check($sformatf("v%0d_busy_ws0", i), 32'(bcnt0), 32'(lat0));
      check($sformatf("v%0d_err_ws2", i), 32'(ecnt2), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_err_ws0", i), 32'(ecnt0), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_rdata_ws2", i), rdata2, vecs[i].exp_rdata);
      check($sformatf("v%0d_rdata_ws0", i), rdata0, vecs[i].exp_rdata);
    end

    // Held level gives one access; dropping and re-raising gives a second.
    run_txn(1'b1, 1'b0, 9'h1FF, 32'h0, 6);
    check("hold1_npulse_ws2", 32'(rcnt2), 32'd1);
    check("hold1_npulse_ws0", 32'(rcnt0), 32'd1);
    run_txn(1'b1, 1'b0, 9'h1FF, 32'h0, 6);
    check("hold2_npulse_ws2", 32'(rcnt2), 32'd1);
    check("hold2_npulse_ws0", 32'(rcnt0), 32'd1);
    check("hold_rdata_ws2", rdata2, 32'h00000001);
    check("hold_rdata_ws0", rdata0, 32'h00000001);

    // Reset lands before either instance commits the write.
    @(negedge clock);
    mem_write = 1'b1; addr = 9'h020; wdata = 32'hCAFEF00D;
    @(negedge clock);
    check("pre_rst_busy_ws2", {31'h0, busy2}, 32'h1);
    reset = 1'b1;
    #1;
    check("rst_busy_ws2", {31'h0, busy2}, 32'h0);
    check("rst_busy_ws0", {31'h0, busy0}, 32'h0);
    check("rst_ready_ws2", {31'h0, ready2}, 32'h0);
    check("rst_ready_ws0", {31'h0, ready0}, 32'h0);
    check("rst_rdata_ws2", rdata2, 32'h0);
    mem_write = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    run_txn(1'b0, 1'b1, 9'h021, 32'h55555555, 7);
    run_txn(1'b1, 1'b0, 9'h021, 32'h0, 7);
    run_txn(1'b1, 1'b0, 9'h020, 32'h0, 7);
    check("rst_drop_ws2", rdata2, 32'h0);
    check("rst_drop_ws0", rdata0, 32'h0);

`ifdef MEM_PARITY_EN
    @(negedge clock);
    parity_inject = 1'b1;
    run_txn(1'b0, 1'b1, 9'h030, 32'h0000000F, 7);
    parity_inject = 1'b0;
    run_txn(1'b1, 1'b0, 9'h030, 32'h0, 7);
    check("par_err_ws2", 32'(ecnt2), 32'd1);
    check("par_err_ws0", 32'(ecnt0), 32'd1);
    check("par_rdata_ws2", rdata2, 32'h0000000F);
    check("par_rdata_ws0", rdata0, 32'h0000000F);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
